bus_arbiter_rr: RTL and testbench

//  Round-robin arbiter for the 4-master shared bus. Samples active-low bus

---
 rtl/bus_arbiter_rr.sv | 86 ++++++++
 tb/tb_bus_arbiter_rr.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for a 4-master shared bus with active-low requests/grants.
// Ownership parks on the last owner; an optional hold limit forces handover when contested.
module bus_arbiter_rr #(
  parameter int HOLD_LIMIT = 16,
  parameter int CNT_W      = 5
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner,
  output logic       preempt
);

  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(HOLD_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [3:0]       req;
  logic [3:0]       grnt;
  logic [CNT_W-1:0] hold_cnt;

  logic             contested;
  logic             found;
  logic [1:0]       cand;
  logic [1:0]       rr_pick;
  logic [1:0]       owner_nxt;
  logic [CNT_W-1:0] hold_nxt;
  logic             preempt_nxt;

  assign req = ~{m3_req_, m2_req_, m1_req_, m0_req_};

  // First requester strictly after the current owner, in round-robin order.
  always_comb begin
    contested = |(req & ~(4'b0001 << owner));
    found     = 1'b0;
    rr_pick   = owner;
    cand      = owner;
    for (int i = 1; i < 4; i++) begin
      cand = owner + 2'(i);
      if (!found && req[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    owner_nxt   = owner;
    hold_nxt    = '0;
    preempt_nxt = 1'b0;
    if (!req[owner]) begin
      owner_nxt = rr_pick;
    end else if (HOLD_LIMIT != 0 && contested && hold_cnt == LIMIT_M1) begin
      owner_nxt   = rr_pick;
      preempt_nxt = 1'b1;
    end else if (contested) begin
      hold_nxt = (hold_cnt == CNT_MAX) ? hold_cnt : hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      owner    <= 2'd0;
      grnt     <= 4'b1110;
      hold_cnt <= '0;
      preempt  <= 1'b0;
    end else begin
      owner    <= owner_nxt;
      grnt     <= ~(4'b0001 << owner_nxt);
      hold_cnt <= hold_nxt;
      preempt  <= preempt_nxt;
    end
  end

  assign m0_grnt_ = grnt[0];
  assign m1_grnt_ = grnt[1];
  assign m2_grnt_ = grnt[2];
  assign m3_grnt_ = grnt[3];

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: vector table, hand-written corner sequences, random vs. reference model.
module tb_bus_arbiter_rr;

  localparam int LIMIT = 4;
  localparam int CW    = 3;

  logic       clk;
  logic       reset_;
  logic       m0_req_, m1_req_, m2_req_, m3_req_;
  logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  logic [1:0] owner;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  int m_own = 0;
  int m_cnt = 0;
  int m_pre = 0;

  bus_arbiter_rr #(.HOLD_LIMIT(LIMIT), .CNT_W(CW)) dut (
    .clk(clk), .reset_(reset_),
    .m0_req_(m0_req_), .m1_req_(m1_req_), .m2_req_(m2_req_), .m3_req_(m3_req_),
    .m0_grnt_(m0_grnt_), .m1_grnt_(m1_grnt_), .m2_grnt_(m2_grnt_), .m3_grnt_(m3_grnt_),
    .owner(owner), .preempt(preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req_n;  // {m3,m2,m1,m0}, active-low
    int         own;
    logic       pre;
  } vec_t;

  vec_t vecs[21];

  function automatic int first_after(input int own, input logic [3:0] rq_n);
    for (int k = 1; k < 4; k++)
      if (!rq_n[(own + k) % 4]) return (own + k) % 4;
    return -1;
  endfunction

  // Reference: arbitration rules applied directly to integer state.
  task automatic model_edge(input logic rst, input logic [3:0] rq_n);
    int nxt;
    bit cont;
    if (!rst) begin
      m_own = 0; m_cnt = 0; m_pre = 0;
      return;
    end
    m_pre = 0;
    cont  = 0;
    for (int k = 0; k < 4; k++)
      if (k != m_own && !rq_n[k]) cont = 1;
    nxt = first_after(m_own, rq_n);
    if (rq_n[m_own]) begin
      m_cnt = 0;
      if (nxt >= 0) m_own = nxt;
    end else if (LIMIT != 0 && cont && m_cnt == LIMIT - 1) begin
      m_own = nxt; m_cnt = 0; m_pre = 1;
    end else if (cont) begin
      m_cnt = (m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1;
    end else begin
      m_cnt = 0;
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] rq_n);
    @(negedge clk);
    reset_ = rst;
    {m3_req_, m2_req_, m1_req_, m0_req_} = rq_n;
    @(posedge clk);
    #1;
    model_edge(rst, rq_n);
  endtask

  task automatic check(input string name, input int exp_own, input logic exp_pre);
    logic [3:0] g, exp_g;
    g     = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};
    exp_g = ~(4'b0001 << exp_own);
    checks++;
    if (owner != 2'(exp_own)) begin
      errors++;
      $display("FAIL %s owner: got %0d expected %0d", name, owner, exp_own);
    end
    checks++;
    if (g !== exp_g) begin
      errors++;
      $display("FAIL %s grants: got %b expected %b", name, g, exp_g);
    end
    checks++;
    if (preempt !== exp_pre) begin
      errors++;
      $display("FAIL %s preempt: got %b expected %b", name, preempt, exp_pre);
    end
  endtask

  task automatic do_reset();
    step(1'b0, 4'b1111);
    step(1'b0, 4'b1111);
  endtask

  initial begin
    logic [3:0] rq;
    logic       rst;
    reset_ = 1'b0;
    {m3_req_, m2_req_, m1_req_, m0_req_} = 4'b1111;

    vecs[0]  = '{4'b1111, 0, 1'b0};  // idle: park on 0
    vecs[1]  = '{4'b1011, 2, 1'b0};  // m2 requests, granted next edge
    vecs[2]  = '{4'b1011, 2, 1'b0};
    vecs[3]  = '{4'b1111, 2, 1'b0};  // release with nobody waiting: park
    vecs[4]  = '{4'b0110, 3, 1'b0};  // m0,m3 request: 3 is first after 2
    vecs[5]  = '{4'b0110, 3, 1'b0};
    vecs[6]  = '{4'b0110, 3, 1'b0};
    vecs[7]  = '{4'b0110, 3, 1'b0};
    vecs[8]  = '{4'b0110, 0, 1'b1};  // 4th contested cycle: forced to 0
    vecs[9]  = '{4'b0110, 0, 1'b0};
    vecs[10] = '{4'b1110, 0, 1'b0};  // uncontested, counter clears
    vecs[11] = '{4'b1100, 0, 1'b0};
    vecs[12] = '{4'b1101, 1, 1'b0};  // m0 releases -> m1
    vecs[13] = '{4'b0101, 1, 1'b0};  // m1 holds, m3 contests
    vecs[14] = '{4'b0101, 1, 1'b0};
    vecs[15] = '{4'b0101, 1, 1'b0};
    vecs[16] = '{4'b0101, 3, 1'b1};
    vecs[17] = '{4'b0101, 3, 1'b0};
    vecs[18] = '{4'b1110, 0, 1'b0};  // 3 releases, only m0 -> wrap to 0
    vecs[19] = '{4'b1111, 0, 1'b0};
    vecs[20] = '{4'b1111, 0, 1'b0};

    do_reset();
    check("reset", 0, 1'b0);

    step(1'b1, 4'b1111);
    for (int i = 0; i < 21; i++) begin
      step(1'b1, vecs[i].req_n);
      check($sformatf("table[%0d]", i), vecs[i].own, vecs[i].pre);
    end

    // All four requesting, each owner releases after 3 cycles of tenure.
    do_reset();
    for (int t = 0; t < 4; t++) begin
      for (int c = 0; c < 3; c++) begin
        step(1'b1, 4'b0000);
        check($sformatf("rr_hold t%0d c%0d", t, c), t, 1'b0);
      end
      rq = 4'b0000;
      rq[t] = 1'b1;
      step(1'b1, rq);
      check($sformatf("rr_handover t%0d", t), (t + 1) % 4, 1'b0);
    end

    // Reset while owner=2 with hold count at 3; count must restart from 0.
    do_reset();
    step(1'b1, 4'b1011);
    check("midrst_grant", 2, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b1, 4'b1010);
    check("midrst_pre", 2, 1'b0);
    step(1'b0, 4'b1010);
    check("midrst_reset", 0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 4'b1010);
      check($sformatf("midrst_cnt c%0d", c), 0, 1'b0);
    end
    step(1'b1, 4'b1010);
    check("midrst_preempt", 2, 1'b1);
    step(1'b1, 4'b1010);
    check("midrst_after", 2, 1'b0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rq  = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 59) != 0);
      step(rst, rq);
      check($sformatf("rand[%0d]", n), m_own, m_pre[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
